cbus_rr_arbiter: RTL

- Round-robin, transaction-locked arbiter that shares the single CBus master port (oreq/oresp) between NUM_INPUTS cache/uncached requesters.
- Sits between the I/D caches plus the I/D uncached bus converters and the top-level CBus.
- Grants one requester for a whole transaction, from first beat to the beat with last.
- Rotates priority after each completed transaction so no requester starves.
- Runs a beat watchdog on the granted transaction.

---
 rtl/cbus_rr_arbiter_pkg.sv | 42 ++++
 rtl/cbus_rr_picker.sv | 46 ++++
 rtl/cbus_rr_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cbus_rr_arbiter_pkg
//   Shared CBus definitions used by the caches, the uncached converters and
//   the CBus arbiter: request/response structs, the burst length encoding,
//   the default watchdog limit and the arbiter state type.
// ---------------------------------------------------------------------------
package cbus_rr_arbiter_pkg;

  // Burst length encoding: a transaction carries len+1 beats.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // Default number of cycles allowed between consecutive beats.
  localparam int CBUS_DEFAULT_TIMEOUT = 1024;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cbus_rr_picker.sv
// ---------------------------------------------------------------------------
// cbus_rr_picker
//   Combinational round-robin selector. Scans ptr+1, ptr+2, ... modulo
//   NUM_INPUTS and returns the first requester with valid set.
//
//   valid_i : one valid bit per requester
//   ptr_i   : index of the most recently served requester
//   found_o : at least one requester is valid
//   idx_o   : selected requester (0 when found_o is low)
// ---------------------------------------------------------------------------
module cbus_rr_picker #(
  parameter int NUM_INPUTS = 4
) (
  input  logic [NUM_INPUTS-1:0]         valid_i,
  input  logic [$clog2(NUM_INPUTS)-1:0] ptr_i,
  output logic                          found_o,
  output logic [$clog2(NUM_INPUTS)-1:0] idx_o
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  always_comb begin
    int                cand;
    logic [IDX_W-1:0]  cand_idx;
    logic              hit;
    hit      = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_INPUTS; off++) begin
      // ptr < NUM_INPUTS and off <= NUM_INPUTS, so one subtraction wraps;
      // this also covers non-power-of-2 requester counts.
      cand = int'(ptr_i) + off;
      if (cand >= NUM_INPUTS) begin
        cand = cand - NUM_INPUTS;
      end
      cand_idx = IDX_W'(cand);
      if (!hit && valid_i[cand_idx]) begin
        hit   = 1'b1;
        idx_o = cand_idx;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cbus_rr_arbiter
//   Round-robin, transaction-locked arbiter sharing one CBus master port
//   between NUM_INPUTS requesters. A requester keeps the grant from its first
//   beat until the beat carrying last; priority then rotates past it. A beat
//   watchdog raises a sticky timeout flag if the memory side stalls.
//
//   clk         : clock
//   resetn      : asynchronous active-low reset
//   ireqs       : requests from each requester (index 0 first after reset)
//   iresps      : responses to each requester ('0 unless granted)
//   oreq        : request towards memory (granted request, or '0)
//   oresp       : response from memory
//   grant_valid : a transaction is currently granted
//   grant_idx   : granted requester, meaningful while grant_valid
//   timeout     : sticky watchdog expiry flag
// ---------------------------------------------------------------------------
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int TIMEOUT    = CBUS_DEFAULT_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  cbus_req_t                     ireqs  [NUM_INPUTS],
  output cbus_resp_t                    iresps [NUM_INPUTS],
  output cbus_req_t                     oreq,
  input  cbus_resp_t                    oresp,
  output logic                          grant_valid,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
  output logic                          timeout
);

  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic [NUM_INPUTS-1:0] valid_vec;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  busy;
  logic                  txn_done;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
  end

  cbus_rr_picker #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_picker (
    .valid_i (valid_vec),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign busy     = (state_q == ARB_BUSY);
  assign txn_done = busy && oresp.ready && oresp.last;

  // Watchdog: counts stalled cycles since the grant or the last beat. The
  // count is held at zero while idle, so entering BUSY starts from zero.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (!busy || oresp.ready) begin
      cnt_d = '0;
    end else begin
      if (cnt_q == CNT_LIMIT) begin
        timeout_d = 1'b1;
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= PTR_RESET;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            idx_q   <= pick_idx;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // The grant is only released on the final beat, even if the
          // owner drops valid early.
          if (txn_done) begin
            ptr_q   <= idx_q;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Zero-latency forwarding of the granted path; everything else reads '0.
  always_comb begin
    oreq        = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    if (busy) begin
      oreq        = ireqs[idx_q];
      grant_valid = 1'b1;
      grant_idx   = idx_q;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          iresps[i] = oresp;
        end
      end
    end
  end

  assign timeout = timeout_q;

endmodule
